mandelbrot_recirc: RTL and testbench



---
 rtl/mandel_pkg.sv | 36 +++
 rtl/mandel_pixel_addr.sv | 49 ++++
 rtl/mandelbrot_recirc.sv | 139 +++++++++++++
 tb/tb_mandelbrot_recirc.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mandel_pkg.sv
// Shared definitions for the Mandelbrot loop: record layout, escape marker and
// the Q5.27 fixed-point format used by the compute stage.
package mandel_pkg;

    localparam int unsigned RECORD_W    = 104;
    localparam int unsigned ADDR_W      = 19;
    localparam int unsigned FRAME_CNT_W = 16;

    localparam int unsigned PX_MSB   = 103;
    localparam int unsigned PX_LSB   = 96;
    localparam int unsigned X_MSB    = 95;
    localparam int unsigned X_LSB    = 64;
    localparam int unsigned Y_MSB    = 63;
    localparam int unsigned Y_LSB    = 32;
    localparam int unsigned ITER_MSB = 31;
    localparam int unsigned ITER_LSB = 0;

    localparam logic [31:0]         ESCAPED_MARK = 32'hFFFF_FFFF;
    localparam logic [RECORD_W-1:0] FRESH_RECORD = '0;

    localparam int unsigned        FIX_W         = 32;
    localparam int unsigned        FIX_INT_BITS  = 5;
    localparam int unsigned        FIX_FRAC_BITS = 27;
    localparam logic signed [31:0] FIX_ONE       = 32'sh0800_0000;
    localparam logic signed [31:0] FIX_FOUR      = 32'sh2000_0000;

    typedef enum logic [0:0] {StSeed, StRun} recirc_state_e;

    function automatic logic [RECORD_W-1:0] make_record(input logic [7:0]  px,
                                                        input logic [31:0] x,
                                                        input logic [31:0] y,
                                                        input logic [31:0] iter);
        return {px, x, y, iter};
    endfunction

endpackage

// File: rtl/mandel_pixel_addr.sv
// Linear pixel address counter with frame wrap, frame-done pulse and frame count.
// Shared by the recirculation loop and the display scanout.
module mandel_pixel_addr
    import mandel_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = 384000
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   advance_i,
    output logic [ADDR_W-1:0]      addr_o,
    output logic                   frame_done_o,
    output logic [FRAME_CNT_W-1:0] frame_count_o
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_PIXELS - 1);

    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
    logic                   wrap;

    always_comb begin
        wrap          = advance_i && (addr_q == LastAddr);
        addr_d        = addr_q;
        if (advance_i) begin
            addr_d = wrap ? '0 : addr_q + 1'b1;
        end
        frame_done_d  = wrap;
        frame_count_d = frame_count_q + FRAME_CNT_W'(wrap);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            addr_q        <= addr_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign addr_o        = addr_q;
    assign frame_done_o  = frame_done_q;
    assign frame_count_o = frame_count_q;

endmodule

// File: rtl/mandelbrot_recirc.sv
// Recirculation stage closing the Mandelbrot iteration loop: seeds, retires, restarts.
// Define MANDEL_RECIRC_STATS_EN to add per-frame escaped/capped pixel counters.
module mandelbrot_recirc
    import mandel_pkg::*;
#(
    parameter int unsigned H_RES        = 800,
    parameter int unsigned V_RES        = 480,
    parameter int unsigned MAX_ITER     = 255,
    parameter logic [7:0]  INSIDE_COLOR = 8'h00
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic [RECORD_W-1:0]    i_Res_Data,
    input  logic                   i_Res_Fifo_Empty,
    output logic                   o_Res_Fifo_Ack,
    output logic [RECORD_W-1:0]    o_Cmp_Data,
    output logic                   o_Cmp_Fifo_Wrreq,
    input  logic                   i_Cmp_Fifo_Full,
    output logic                   o_Fb_Wr,
    output logic [ADDR_W-1:0]      o_Fb_Addr,
    output logic [7:0]             o_Fb_Data,
    input  logic                   i_Fb_Busy,
    output logic                   o_Frame_Done,
    output logic [FRAME_CNT_W-1:0] o_Frame_Count
`ifdef MANDEL_RECIRC_STATS_EN
    ,
    output logic [18:0]            o_Escaped_Count,
    output logic [18:0]            o_Capped_Count
`endif
);

    localparam int unsigned       NumPixels = H_RES * V_RES;
    localparam logic [ADDR_W-1:0] LastAddr  = ADDR_W'(NumPixels - 1);

    recirc_state_e     state_q, state_d;
    logic [ADDR_W-1:0] seed_cnt_q, seed_cnt_d;
    logic              escaped, capped, retire, fire, push;

    always_comb begin
        escaped = (i_Res_Data[X_MSB:X_LSB] == ESCAPED_MARK) &&
                  (i_Res_Data[Y_MSB:Y_LSB] == ESCAPED_MARK);
        capped  = !escaped && (i_Res_Data[ITER_MSB:ITER_LSB] >= MAX_ITER);
        retire  = escaped || capped;
    end

    always_comb begin
        state_d    = state_q;
        seed_cnt_d = seed_cnt_q;
        fire       = 1'b0;
        push       = 1'b0;
        o_Cmp_Data = FRESH_RECORD;
        unique case (state_q)
            StSeed: begin
                push = !i_Cmp_Fifo_Full && !i_Reset;
                if (push) begin
                    if (seed_cnt_q == LastAddr) begin
                        seed_cnt_d = '0;
                        state_d    = StRun;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end
            end
            StRun: begin
                fire = !i_Reset && !i_Res_Fifo_Empty && !i_Cmp_Fifo_Full &&
                       (!retire || !i_Fb_Busy);
                push = fire;
                // A retired pixel restarts from a fresh record so rendering never stops.
                o_Cmp_Data = retire ? FRESH_RECORD : i_Res_Data;
            end
            default: state_d = StSeed;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q    <= StSeed;
            seed_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            seed_cnt_q <= seed_cnt_d;
        end
    end

    assign o_Res_Fifo_Ack   = fire;
    assign o_Cmp_Fifo_Wrreq = push;
    assign o_Fb_Wr          = fire && retire;
    assign o_Fb_Data        = escaped ? i_Res_Data[PX_MSB:PX_LSB] : INSIDE_COLOR;

    mandel_pixel_addr #(
        .NUM_PIXELS(NumPixels)
    ) u_pixel_addr (
        .clk_i        (i_Clk),
        .reset_i      (i_Reset),
        .advance_i    (fire),
        .addr_o       (o_Fb_Addr),
        .frame_done_o (o_Frame_Done),
        .frame_count_o(o_Frame_Count)
    );

`ifdef MANDEL_RECIRC_STATS_EN
    logic [18:0] esc_cnt_q, esc_cnt_d, cap_cnt_q, cap_cnt_d;
    logic [18:0] esc_out_q, esc_out_d, cap_out_q, cap_out_d;
    logic        frame_wrap;

    always_comb begin
        frame_wrap = fire && (o_Fb_Addr == LastAddr);
        esc_cnt_d  = esc_cnt_q + 19'(fire && escaped);
        cap_cnt_d  = cap_cnt_q + 19'(fire && capped);
        esc_out_d  = esc_out_q;
        cap_out_d  = cap_out_q;
        // The wrapping record itself belongs to the frame being published.
        if (frame_wrap) begin
            esc_out_d = esc_cnt_d;
            cap_out_d = cap_cnt_d;
            esc_cnt_d = '0;
            cap_cnt_d = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            esc_cnt_q <= '0;
            cap_cnt_q <= '0;
            esc_out_q <= '0;
            cap_out_q <= '0;
        end else begin
            esc_cnt_q <= esc_cnt_d;
            cap_cnt_q <= cap_cnt_d;
            esc_out_q <= esc_out_d;
            cap_out_q <= cap_out_d;
        end
    end

    assign o_Escaped_Count = esc_out_q;
    assign o_Capped_Count  = cap_out_q;
`endif

endmodule

// File: tb/tb_mandelbrot_recirc.sv
// Directed bench for mandelbrot_recirc on a 4x2 frame with MAX_ITER = 3.
module tb_mandelbrot_recirc;
    import mandel_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [RECORD_W-1:0]    res_data;
    logic                   res_empty;
    logic                   res_ack;
    logic [RECORD_W-1:0]    cmp_data;
    logic                   cmp_wrreq;
    logic                   cmp_full;
    logic                   fb_wr;
    logic [ADDR_W-1:0]      fb_addr;
    logic [7:0]             fb_data;
    logic                   fb_busy;
    logic                   frame_done;
    logic [FRAME_CNT_W-1:0] frame_count;
`ifdef MANDEL_RECIRC_STATS_EN
    logic [18:0]            esc_count;
    logic [18:0]            cap_count;
`endif

    always #5 clk = ~clk;

    mandelbrot_recirc #(
        .H_RES       (4),
        .V_RES       (2),
        .MAX_ITER    (3),
        .INSIDE_COLOR(8'h00)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_Res_Data      (res_data),
        .i_Res_Fifo_Empty(res_empty),
        .o_Res_Fifo_Ack  (res_ack),
        .o_Cmp_Data      (cmp_data),
        .o_Cmp_Fifo_Wrreq(cmp_wrreq),
        .i_Cmp_Fifo_Full (cmp_full),
        .o_Fb_Wr         (fb_wr),
        .o_Fb_Addr       (fb_addr),
        .o_Fb_Data       (fb_data),
        .i_Fb_Busy       (fb_busy),
        .o_Frame_Done    (frame_done),
        .o_Frame_Count   (frame_count)
`ifdef MANDEL_RECIRC_STATS_EN
        ,
        .o_Escaped_Count (esc_count),
        .o_Capped_Count  (cap_count)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [RECORD_W-1:0] act,
                         input logic [RECORD_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge; outputs are checked 1 ns later.
    task automatic step(input logic r, input logic [RECORD_W-1:0] head,
                        input logic e, input logic f, input logic b);
        @(posedge clk);
        #1;
        rst       = r;
        res_data  = head;
        res_empty = e;
        cmp_full  = f;
        fb_busy   = b;
        #1;
    endtask

    typedef struct {
        logic [RECORD_W-1:0] head;
        logic                empty;
        logic                full;
        logic                busy;
        logic                fire;
        logic                fbwr;
        logic [ADDR_W-1:0]   addr;
        logic [7:0]          px;
        logic [RECORD_W-1:0] push;
    } vec_t;

    vec_t vecs[10];

    logic [RECORD_W-1:0] pass1, pass3, esc7, capd, half, escab;
    int                  exp_pushes;
    logic                exp_push;

    initial begin
        pass1 = make_record(8'hFF, 32'h1234, 32'h5678, 32'd1);
        pass3 = make_record(8'h11, 32'd5, 32'd6, 32'd2);
        esc7  = make_record(8'h07, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd9);
        capd  = make_record(8'h33, 32'd10, 32'd20, 32'd3);
        half  = make_record(8'h55, 32'hFFFF_FFFF, 32'd0, 32'd1);
        escab = make_record(8'hAB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd300);

        //          head   empty full busy  fire fbwr addr px     push
        vecs[0] = '{pass1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'd0, 8'h00, pass1};
        vecs[1] = '{pass1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 19'd0, 8'h00, '0};
        vecs[2] = '{pass1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 19'd0, 8'h00, '0};
        vecs[3] = '{pass3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 19'd0, 8'h00, pass3};
        vecs[4] = '{esc7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 19'd2, 8'h07, '0};
        vecs[5] = '{capd,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 19'd3, 8'h00, '0};
        vecs[6] = '{make_record(8'h44, 32'd1, 32'd2, 32'd100),
                           1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 19'd0, 8'h00, '0};
        vecs[7] = '{half,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 19'd0, 8'h00, half};
        vecs[8] = '{esc7,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 19'd5, 8'h07, '0};
        vecs[9] = '{escab, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 19'd6, 8'hAB, '0};

        rst = 1'b1; res_data = pass1; res_empty = 1'b0; cmp_full = 1'b0; fb_busy = 1'b0;

        // Reset: strobes held low even with a valid head and free FIFO.
        step(1'b1, pass1, 1'b0, 1'b0, 1'b0);
        step(1'b1, pass1, 1'b0, 1'b0, 1'b0);
        check("rst_ack", 104'(res_ack), 104'd0);
        check("rst_wrreq", 104'(cmp_wrreq), 104'd0);
        check("rst_fbwr", 104'(fb_wr), 104'd0);
        check("rst_count", 104'(frame_count), 104'd0);
        check("rst_done", 104'(frame_done), 104'd0);

        // Seed: eight fresh pushes, never popping the non-empty result FIFO.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, pass1, 1'b0, 1'b0, 1'b0);
            check($sformatf("seed_wrreq[%0d]", i), 104'(cmp_wrreq), 104'd1);
            check($sformatf("seed_ack[%0d]", i), 104'(res_ack), 104'd0);
            check($sformatf("seed_data[%0d]", i), cmp_data, FRESH_RECORD);
        end
        step(1'b0, pass1, 1'b1, 1'b0, 1'b0);
        check("seed_end_wrreq", 104'(cmp_wrreq), 104'd0);

        // RUN vectors, address starts at 0.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, vecs[i].head, vecs[i].empty, vecs[i].full, vecs[i].busy);
            check($sformatf("v%0d_ack", i), 104'(res_ack), 104'(vecs[i].fire));
            check($sformatf("v%0d_wrreq", i), 104'(cmp_wrreq), 104'(vecs[i].fire));
            check($sformatf("v%0d_fbwr", i), 104'(fb_wr), 104'(vecs[i].fbwr));
            if (vecs[i].fire) check($sformatf("v%0d_push", i), cmp_data, vecs[i].push);
            if (vecs[i].fbwr) begin
                check($sformatf("v%0d_addr", i), 104'(fb_addr), 104'(vecs[i].addr));
                check($sformatf("v%0d_px", i), 104'(fb_data), 104'(vecs[i].px));
            end
        end

        // Capped head stalled by a busy framebuffer, then retired at the last address.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, capd, 1'b0, 1'b0, 1'b1);
            check($sformatf("busy_ack[%0d]", i), 104'(res_ack), 104'd0);
            check($sformatf("busy_wrreq[%0d]", i), 104'(cmp_wrreq), 104'd0);
            check($sformatf("busy_fbwr[%0d]", i), 104'(fb_wr), 104'd0);
        end
        step(1'b0, capd, 1'b0, 1'b0, 1'b0);
        check("rel_ack", 104'(res_ack), 104'd1);
        check("rel_fbwr", 104'(fb_wr), 104'd1);
        check("rel_addr", 104'(fb_addr), 104'd7);
        check("rel_px", 104'(fb_data), 104'h00);
        check("rel_push", cmp_data, FRESH_RECORD);
        check("rel_done", 104'(frame_done), 104'd0);
        step(1'b0, capd, 1'b1, 1'b0, 1'b0);
        check("wrap_done", 104'(frame_done), 104'd1);
        check("wrap_count", 104'(frame_count), 104'd1);
        step(1'b0, capd, 1'b1, 1'b0, 1'b0);
        check("wrap_done_clr", 104'(frame_done), 104'd0);
        check("wrap_count_hold", 104'(frame_count), 104'd1);

        // Two pass-throughs so the address is mid-frame, then reset.
        step(1'b0, pass1, 1'b0, 1'b0, 1'b0);
        step(1'b0, pass1, 1'b0, 1'b0, 1'b0);
        check("mid_addr", 104'(fb_addr), 104'd1);
        step(1'b1, pass1, 1'b0, 1'b0, 1'b0);
        check("mid_rst_ack", 104'(res_ack), 104'd0);
        step(1'b1, pass1, 1'b0, 1'b0, 1'b0);
        check("mid_rst_count", 104'(frame_count), 104'd0);

        // Seed again while the compute FIFO toggles full every other cycle.
        exp_pushes = 0;
        for (int i = 0; i < 24; i++) begin
            step(1'b0, pass1, 1'b1, 1'((i % 2) == 1), 1'b0);
            exp_push = (i % 2 == 0) && (exp_pushes < 8);
            check($sformatf("tog_wrreq[%0d]", i), 104'(cmp_wrreq), 104'(exp_push));
            if (exp_push) begin
                check($sformatf("tog_data[%0d]", i), cmp_data, FRESH_RECORD);
                exp_pushes++;
            end
        end

        // Address counter restarted from zero after the reset.
        step(1'b0, esc7, 1'b0, 1'b0, 1'b0);
        check("post_rst_fbwr", 104'(fb_wr), 104'd1);
        check("post_rst_addr", 104'(fb_addr), 104'd0);
        check("post_rst_px", 104'(fb_data), 104'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
